// File: rtl/add_bit_full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : Single-bit combinational full adder.
// Revision    : 1.0
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/add_bit.sv
`default_nettype none
// ============================================================================
// Module      : add_bit
// Description : Bit-serial LSB-first adder with word-framed carry tracking.
// Revision    : 1.0
// ============================================================================
module add_bit #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic sof,
    input  logic a,
    input  logic b,
    output logic c,
    output logic c_valid,
    output logic carry_out,
    output logic word_done
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_carry_q;
    logic [c_CNT_W-1:0] w_idx;
    logic               w_cin;
    logic               w_cout;
    logic               w_last;

    // A start-of-word bit restarts indexing at zero, abandoning any partial word.
    assign w_idx  = sof ? '0 : r_bit_cnt;
    assign w_cin  = (sof || (r_bit_cnt == '0)) ? 1'b0 : r_carry_q;
    assign w_last = (w_idx == c_LAST);

    full_adder_bit u_fa (
        .a    (a),
        .b    (b),
        .cin  (w_cin),
        .s    (c),
        .cout (w_cout)
    );

    assign c_valid = in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_carry_q <= 1'b0;
            carry_out <= 1'b0;
            word_done <= 1'b0;
        end else if (in_valid) begin
            if (w_last) begin
                carry_out <= w_cout;
                r_carry_q <= 1'b0;
                r_bit_cnt <= '0;
                word_done <= 1'b1;
            end else begin
                r_carry_q <= w_cout;
                r_bit_cnt <= w_idx + 1'b1;
                word_done <= 1'b0;
            end
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_bit
// Description : Scoreboard bench for add_bit (WIDTH=4) with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_add_bit;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic sof = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c, c_valid, carry_out, word_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_c_q[$];
    logic exp_co_q[$];

    add_bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sof       (sof),
        .a         (a),
        .b         (b),
        .c         (c),
        .c_valid   (c_valid),
        .carry_out (carry_out),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one valid bit for the coming edge; expected sum bit and, on a word's
    // last bit, the expected final carry go into the scoreboard queues.
    task automatic send_bit(input logic ia, input logic ib, input logic isof,
                            input logic exp_c, input logic last, input logic exp_co);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b1; sof = isof; a = ia; b = ib;
        exp_c_q.push_back(exp_c);
        if (last) exp_co_q.push_back(exp_co);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0; sof = 1'b0; a = 1'b0; b = 1'b0;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                             input logic [WIDTH-1:0] vc, input logic co, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit(va[i], vb[i], (i == 0), vc[i], (i == WIDTH - 1), co);
            if (gap > 0 && i != WIDTH - 1) idle(gap);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a sum bit or a word_done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (c_valid) begin
                    if (exp_c_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL c_unexpected: c_valid=1 with empty scoreboard at %0t", $time);
                    end else begin
                        check("c_bit", c, exp_c_q.pop_front());
                    end
                end
                if (word_done) begin
                    if (exp_co_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL word_done_unexpected: got 1 required 0 at %0t", $time);
                    end else begin
                        check("carry_out", carry_out, exp_co_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] ab;
        // Reset state and combinational sum with no state contribution.
        repeat (3) @(posedge clk);
        #1;
        check("rst_carry_out", carry_out, 1'b0);
        check("rst_word_done", word_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a = ab[1]; b = ab[0];
            #1;
            check("comb_c", c, ab[1] ^ ab[0]);
            check("comb_c_valid", c_valid, 1'b0);
        end
        a = 1'b0; b = 1'b0;

        // 3+5 = 8, no carry
        send_word(4'b0011, 4'b0101, 4'b1000, 1'b0, 0);
        // 15+1 = 16, carry; back-to-back 0+0
        send_word(4'b1111, 4'b0001, 4'b0000, 1'b1, 0);
        send_word(4'b0000, 4'b0000, 4'b0000, 1'b0, 0);
        idle(2);
        check("co_after_zero_word", carry_out, 1'b0);

        // 3+5 with gaps between bits
        send_word(4'b0011, 4'b0101, 4'b1000, 1'b0, 2);
        idle(1);

        // Abandoned partial word, then 15+1
        send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(4'b1111, 4'b0001, 4'b0000, 1'b1, 0);
        idle(2);
        check("co_after_15p1", carry_out, 1'b1);

        // Reset after bit 2 of 15+1, then 1+1
        send_bit(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0; sof = 1'b0;
        @(posedge clk);
        #1;
        check("co_after_reset", carry_out, 1'b0);
        check("wd_after_reset", word_done, 1'b0);
        send_word(4'b0001, 4'b0001, 4'b0010, 1'b0, 0);
        idle(3);

        check("c_queue_drained", 1'(exp_c_q.size() == 0), 1'b1);
        check("co_queue_drained", 1'(exp_co_q.size() == 0), 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
